led_scan_driver: RTL

- Time-multiplexed 7-segment scan stage, directly downstream of the LED driver that produces LED_OutArray (8 digits × LED_OUT_WIDTH segment codes).
- Drives one shared segment bus and a one-hot digit-select bus to the board's 8-digit display, one digit per slot.
- Inserts a blanking gap between digits to suppress ghosting and emits a per-frame tick.

---
 rtl/led_scan_driver_pkg.sv | 27 ++
 rtl/led_scan_driver_timer.sv | 50 +++++
 rtl/led_scan_driver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/led_scan_driver_pkg.sv
// Shared types and constants for the LED scan stage.
//   LED_OUT_WIDTH  : segment code width per digit
//   LED_NUM_DIGITS : digits carried by LED_OutArray
//   LED_SCAN_DIV   : default clocks per digit slot
//   LED_SCAN_BLANK : default dark clocks at the start of each slot
//   scan_state_e   : scan FSM states
//   width_of()     : counter width for a modulus, never below 1
package led_scan_driver_pkg;

   localparam int LED_OUT_WIDTH  = 8;
   localparam int LED_NUM_DIGITS = 8;
   localparam int LED_SCAN_DIV   = 50000;
   localparam int LED_SCAN_BLANK = 1000;

   typedef logic [LED_NUM_DIGITS*LED_OUT_WIDTH-1:0] led_out_array_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      LIT   = 2'd2
   } scan_state_e;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_scan_driver_timer.sv
// Slot counter for the LED scan stage. Counts 0..SCAN_DIV-1 once per digit slot.
//   clk, rst        : clock, async active-low reset
//   clr             : force the counter to 0 on the next edge (takes priority)
//   inc             : advance the counter, wrapping at SCAN_DIV-1
//   slot_cnt        : current count
//   slot_cnt_nxt    : value the counter takes on the next edge
//   tc              : current count is SCAN_DIV-1 (last cycle of the slot)
//   blank_end       : current count is BLANK_CYCLES-1 (never set when BLANK_CYCLES is 0)
module led_scan_driver_timer #(
   parameter int SCAN_DIV     = 8,
   parameter int BLANK_CYCLES = 2,
   parameter int CW           = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] slot_cnt,
   output logic [CW-1:0] slot_cnt_nxt,
   output logic          tc,
   output logic          blank_end
);

   logic [CW-1:0] slot_cnt_q;
   logic [CW-1:0] slot_cnt_d;

   assign tc        = (slot_cnt_q == CW'(SCAN_DIV - 1));
   assign blank_end = (BLANK_CYCLES != 0) && (slot_cnt_q == CW'(BLANK_CYCLES - 1));

   always_comb begin
      slot_cnt_d = slot_cnt_q;
      if (clr) begin
         slot_cnt_d = '0;
      end else if (inc) begin
         slot_cnt_d = tc ? '0 : slot_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_cnt_q <= '0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
      end
   end

   assign slot_cnt     = slot_cnt_q;
   assign slot_cnt_nxt = slot_cnt_d;

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 7-segment scan stage. Shows one digit of segArray per slot
// of SCAN_DIV clocks, the first BLANK_CYCLES of each slot dark to avoid ghosting,
// and pulses frameTick on the last cycle of the final digit's slot.
//   clk        : system clock
//   rst        : async active-low reset
//   enable     : scan enable, low forces the display dark and restarts the scan
//   segArray   : NUM_DIGITS segment codes, digit i at [i*LED_OUT_WIDTH +: LED_OUT_WIDTH]
//   brightness : duty level 0..7, present only when LED_SCAN_DIM_EN is defined
//   segOut     : segment pins (inverted when SEG_ACTIVE_LOW)
//   digitSel   : one-hot digit pins (inverted when DIG_ACTIVE_LOW)
//   frameTick  : one-cycle pulse at end of frame
// Optional macro LED_SCAN_DIM_EN: brightness-controlled duty within the lit part.
//
// state | meaning
// IDLE  | display dark, waiting for enable
// BLANK | start of a slot, display dark, code for this digit latched at the end
// LIT   | latched code driven on the selected digit until the slot ends
module led_scan_driver
   import led_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS     = LED_NUM_DIGITS,
   parameter int SCAN_DIV       = LED_SCAN_DIV,
   parameter int BLANK_CYCLES   = LED_SCAN_BLANK,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic [NUM_DIGITS*LED_OUT_WIDTH-1:0] segArray,
`ifdef LED_SCAN_DIM_EN
   input  logic [2:0]                          brightness,
`endif
   output logic [LED_OUT_WIDTH-1:0]            segOut,
   output logic [NUM_DIGITS-1:0]               digitSel,
   output logic                                frameTick
);

   localparam int CW = width_of(SCAN_DIV);
   localparam int DW = width_of(NUM_DIGITS);
   localparam logic [LED_OUT_WIDTH-1:0] SEG_DARK = SEG_ACTIVE_LOW ? '1 : '0;
   localparam logic [NUM_DIGITS-1:0]    DIG_DARK = DIG_ACTIVE_LOW ? '1 : '0;

   scan_state_e              state_q, state_d;
   logic [DW-1:0]            digit_idx_q, digit_idx_d;
   logic [LED_OUT_WIDTH-1:0] code_q, code_d;
   logic [LED_OUT_WIDTH-1:0] seg_out_q, seg_out_d;
   logic [NUM_DIGITS-1:0]    digit_sel_q, digit_sel_d;
   logic                     frame_tick_q, frame_tick_d;

   logic                     latch;
   logic                     cnt_clr;
   logic                     cnt_inc;
   logic [CW-1:0]            slot_cnt;
   logic [CW-1:0]            slot_cnt_nxt;
   logic                     tc;
   logic                     blank_end;
   logic                     lit_on;

   led_scan_driver_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CW           (CW)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .clr          (cnt_clr),
      .inc          (cnt_inc),
      .slot_cnt     (slot_cnt),
      .slot_cnt_nxt (slot_cnt_nxt),
      .tc           (tc),
      .blank_end    (blank_end)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         digit_idx_q  <= '0;
         code_q       <= '0;
         seg_out_q    <= SEG_DARK;
         digit_sel_q  <= DIG_DARK;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_idx_q  <= digit_idx_d;
         code_q       <= code_d;
         seg_out_q    <= seg_out_d;
         digit_sel_q  <= digit_sel_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   // With no blanking the slot goes straight from one LIT to the next, latching
   // the new digit's code on the slot boundary.
   always_comb begin
      state_d     = state_q;
      digit_idx_d = digit_idx_q;
      latch       = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      if (!enable) begin
         state_d     = IDLE;
         digit_idx_d = '0;
         cnt_clr     = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               digit_idx_d = '0;
               cnt_clr     = 1'b1;
               if (BLANK_CYCLES == 0) begin
                  state_d = LIT;
                  latch   = 1'b1;
               end else begin
                  state_d = BLANK;
               end
            end
            BLANK: begin
               cnt_inc = 1'b1;
               if (blank_end) begin
                  state_d = LIT;
                  latch   = 1'b1;
               end
            end
            LIT: begin
               cnt_inc = 1'b1;
               if (tc) begin
                  digit_idx_d = (digit_idx_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + DW'(1);
                  if (BLANK_CYCLES == 0) begin
                     latch = 1'b1;
                  end else begin
                     state_d = BLANK;
                  end
               end
            end
            default: begin
               state_d     = IDLE;
               digit_idx_d = '0;
               cnt_clr     = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      code_d = code_q;
      if (latch) begin
         code_d = segArray[digit_idx_d*LED_OUT_WIDTH +: LED_OUT_WIDTH];
      end
   end

`ifdef LED_SCAN_DIM_EN
   logic [2:0]  bright_q, bright_d;
   logic [31:0] lit_cnt;
   logic [31:0] lit_len;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bright_q <= '0;
      end else begin
         bright_q <= bright_d;
      end
   end

   // Only meaningful while the next state is LIT, where slot_cnt_nxt >= BLANK_CYCLES.
   always_comb begin
      bright_d = latch ? brightness : bright_q;
      lit_cnt  = 32'(slot_cnt_nxt) - 32'(BLANK_CYCLES);
      lit_len  = ((32'(bright_d) + 32'd1) * 32'(SCAN_DIV - BLANK_CYCLES)) >> 3;
      lit_on   = (lit_cnt < lit_len);
   end
`else
   assign lit_on = 1'b1;
`endif

   // Output registers load the values that belong to the next state, so the pins
   // track the FSM with no extra cycle of lag.
   always_comb begin
      logic [LED_OUT_WIDTH-1:0] seg_raw;
      logic [NUM_DIGITS-1:0]    dig_raw;
      seg_raw = '0;
      dig_raw = '0;
      if ((state_d == LIT) && lit_on) begin
         seg_raw = code_d;
         dig_raw = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_d;
      end
      seg_out_d    = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      digit_sel_d  = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
      frame_tick_d = (state_d == LIT) && (slot_cnt_nxt == CW'(SCAN_DIV - 1)) &&
                     (digit_idx_d == DW'(NUM_DIGITS - 1));
   end

   assign segOut    = seg_out_q;
   assign digitSel  = digit_sel_q;
   assign frameTick = frame_tick_q;

   blank_range_a: assert property (@(posedge clk) disable iff (!rst) BLANK_CYCLES < SCAN_DIV);

endmodule
